// File: rtl/bcd_ctrl_pkg.sv
// Shared types and constants for the BCD counter controller and its digit cells.
package bcd_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // A preset digit outside 0..9 is forced to 0 so the count always stays valid BCD.
    function automatic logic [3:0] bcd_sanitize(input logic [3:0] d);
        return (d > BCD_MAX) ? 4'd0 : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register: synchronous load beats increment, and 9 wraps to 0.
module bcd_digit
    import bcd_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       ld,
    input  logic [3:0] ld_val,
    output logic [3:0] d,
    output logic       is_nine
);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d <= 4'd0;
        end else if (ld) begin
            d <= ld_val;
        end else if (en) begin
            d <= (d == BCD_MAX) ? 4'd0 : d + 4'd1;
        end
    end

    assign is_nine = (d == BCD_MAX);

endmodule

// File: rtl/bcd_count_ctrl.sv
// Start/stop/clear/load sequencer for a chain of cascaded BCD digits, with prescaler and terminal stop.
module bcd_count_ctrl
    import bcd_ctrl_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                clear,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic [4*DIGITS-1:0] limit,
    output logic [4*DIGITS-1:0] q,
    output logic [DIGITS-1:0]   dig_en,
    output logic                running,
    output logic                done
);

    localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    state_t              state;
    logic [PW-1:0]       pcnt;
    logic [DIGITS-1:0]   nine;
    logic [4*DIGITS-1:0] q_inc;
    logic [4*DIGITS-1:0] ld_word;
    logic                tick;
    logic                carry;
    logic                load_ok;
    logic                digit_ld;
    logic                hit;

    assign tick     = (state == RUN) && (pcnt == PS_LAST);
    assign load_ok  = load && (state != RUN);
    assign digit_ld = clear || load_ok;
    // Terminal compare looks at the value the digits are about to take, so done aligns with q == limit.
    assign hit      = tick && (limit != '0) && (q_inc == limit);
    assign running  = (state == RUN);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        dig_en  = '0;
        q_inc   = q;
        ld_word = '0;
        carry   = tick;
        for (int i = 0; i < DIGITS; i++) begin
            dig_en[i] = carry;
            carry     = carry && nine[i];
            if (dig_en[i]) begin
                q_inc[4*i +: 4] = nine[i] ? 4'd0 : q[4*i +: 4] + 4'd1;
            end
            if (!clear) begin
                ld_word[4*i +: 4] = bcd_sanitize(load_val[4*i +: 4]);
            end
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk     (clk),
            .reset   (reset),
            .en      (dig_en[g] && !clear),
            .ld      (digit_ld),
            .ld_val  (ld_word[4*g +: 4]),
            .d       (q[4*g +: 4]),
            .is_nine (nine[g])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            pcnt  <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                state <= IDLE;
                pcnt  <= '0;
            end else if (load_ok) begin
                pcnt <= '0;
                if (state == DONE) state <= PAUSE;
            end else if (state == RUN) begin
                pcnt <= tick ? '0 : pcnt + PW'(1);
                if (hit) begin
                    state <= DONE;
                    done  <= 1'b1;
                end else if (stop) begin
                    state <= PAUSE;
                end
            end else if (start) begin
                state <= RUN;
            end
        end
    end

endmodule
